// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI write-channel arbiter: state encoding,
// channel numbering and default sizing.
package spi_arb_pkg;

    // Arbiter states
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    // SPI channel numbering
    localparam logic CH_ADF4002 = 1'b0;
    localparam logic CH_LMX2594 = 1'b1;

    // Default sizing
    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_TIMEOUT = 1024;
    localparam int unsigned DEF_GAP_CYC = 4;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester selector: round-robin from a pointer, or fixed
// priority where the lowest index wins.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               mode,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int unsigned pos;

    // Walk candidates from the least preferred to the most preferred so the
    // last hit (the preferred one) is what remains in index.
    always_comb begin
        valid = |req;
        index = '0;
        pos   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (mode) begin
                pos = 32'(i);
            end else begin
                pos = 32'(ptr) + 32'(i);
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
            end
            if (req[pos]) begin
                index = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares the two SPI write channels (ch0 ADF4002, ch1 LMX2594) between
// several requesters. One 24-bit write per grant, one transaction in flight,
// with a timeout on the master handshake and a forced CS-high gap after it.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prio_mode,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_ch,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    input  logic [1:0]                spi_ready,
    output logic [1:0]                spi_start,
    output logic                      spi_dir,
    output logic [DATA_W-1:0]         spi_data_tx,
    output logic [7:0]                spi_data_depth
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               ch_q, ch_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [1:0]         start_q, start_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               ch_ready;
    logic               tmo_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .mode  (prio_mode),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign ch_ready = spi_ready[ch_q];
    assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // Next-state logic for the grant / handshake / gap sequence
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ch_d      = ch_q;
        tx_d      = tx_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        start_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d         = pick_idx;
                    ch_d            = req_ch[pick_idx];
                    tx_d            = req_data[pick_idx*DATA_W +: DATA_W];
                    ack_d[pick_idx] = 1'b1;
                    if (!prio_mode) begin
                        rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : pick_idx + IDX_W'(1);
                    end
                    state_d = ISSUE;
                end
            end
            // Not timed: a master that never becomes ready stalls here.
            ISSUE: begin
                if (ch_ready) begin
                    start_d   = {ch_q == CH_LMX2594, ch_q == CH_ADF4002};
                    tmo_cnt_d = '0;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!ch_ready) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    state_d   = WAIT_DONE;
                end else if (tmo_hit) begin
                    err_d[grant_q] = 1'b1;
                    gap_cnt_d      = '0;
                    state_d        = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (ch_ready) begin
                    done_d[grant_q] = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = GAP;
                end else if (tmo_hit) begin
                    err_d[grant_q] = 1'b1;
                    gap_cnt_d      = '0;
                    state_d        = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transaction silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ch_q      <= 1'b0;
            tx_q      <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            start_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ch_q      <= ch_d;
            tx_q      <= tx_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
        end
    end

    assign ack            = ack_q;
    assign done           = done_q;
    assign err            = err_q;
    assign spi_start      = start_q;
    assign busy           = (state_q != IDLE);
    assign spi_dir        = 1'b0;
    assign spi_data_tx    = tx_q;
    assign spi_data_depth = 8'(DATA_W);

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter. u_dut talks to an ideal SPI master model;
// u_to has TIMEOUT = 16 and a master that never drops ready.
module tb_spi_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              prio_mode;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_ch;
    logic [NREQ*DW-1:0] req_data;

    logic [NREQ-1:0] ack, done, err;
    logic            busy;
    logic [1:0]      spi_ready, spi_start;
    logic            spi_dir;
    logic [DW-1:0]   spi_data_tx;
    logic [7:0]      spi_data_depth;

    logic [NREQ-1:0] to_ack, to_done, to_err;
    logic            to_busy;
    logic [1:0]      to_ready, to_start;
    logic            to_dir;
    logic [DW-1:0]   to_tx;
    logic [7:0]      to_depth;

    int n_vec  = 0;
    int n_miss = 0;

    spi_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .TIMEOUT (40),
        .GAP_CYC (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .prio_mode      (prio_mode),
        .req            (req),
        .req_ch         (req_ch),
        .req_data       (req_data),
        .ack            (ack),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .spi_ready      (spi_ready),
        .spi_start      (spi_start),
        .spi_dir        (spi_dir),
        .spi_data_tx    (spi_data_tx),
        .spi_data_depth (spi_data_depth)
    );

    spi_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .TIMEOUT (16),
        .GAP_CYC (4)
    ) u_to (
        .clk            (clk),
        .rst            (rst),
        .prio_mode      (prio_mode),
        .req            (req),
        .req_ch         (req_ch),
        .req_data       (req_data),
        .ack            (to_ack),
        .done           (to_done),
        .err            (to_err),
        .busy           (to_busy),
        .spi_ready      (to_ready),
        .spi_start      (to_start),
        .spi_dir        (to_dir),
        .spi_data_tx    (to_tx),
        .spi_data_depth (to_depth)
    );

    assign to_ready = 2'b11;

    // Ideal master: ready drops the cycle after start and stays low master_n cycles
    int   busy_left [2];
    int   master_n;
    logic hold0;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) busy_left[c] <= 0;
            else if (spi_start[c]) busy_left[c] <= master_n;
            else if (busy_left[c] > 0) busy_left[c] <= busy_left[c] - 1;
        end
    end

    assign spi_ready[0] = (busy_left[0] == 0) && !hold0;
    assign spi_ready[1] = (busy_left[1] == 0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] probe(input int sel);
        case (sel)
            0:       return {5'b0, ack};
            1:       return {6'b0, spi_start};
            2:       return {5'b0, done};
            4:       return {5'b0, to_ack};
            5:       return {6'b0, to_start};
            6:       return {2'b0, to_done, to_err};
            7:       return {7'b0, ~busy};
            default: return 8'h0;
        endcase
    endfunction

    // Cycles until probe(sel) is non-zero, or -1 when the bound expires
    task automatic wait_for(input int sel, input int limit, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < limit) begin
            tick();
            cyc++;
            hit = (probe(sel) != 0);
        end
        if (!hit) cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int bad;
        int exp_g;

        rst       = 1'b1;
        prio_mode = 1'b0;
        req       = '0;
        req_ch    = '0;
        req_data  = '0;
        hold0     = 1'b0;
        master_n  = 24;
        tick();
        tick();

        // Reset state
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_start", 32'(spi_start), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_dir", 32'(spi_dir), 32'h0);
        check_eq("rst_tx", 32'(spi_data_tx), 32'h0);
        check_eq("rst_depth", 32'(spi_data_depth), 32'd24);
        rst = 1'b0;

        // Single request on ch1, master busy 24 cycles
        req_ch         = 3'b010;
        req_data[47:24] = 24'h00A5C3;
        req            = 3'b010;
        wait_for(0, 10, c);
        check_eq("t1_ack_lat", 32'(c), 32'd1);
        check_eq("t1_ack", 32'(ack), 32'h2);
        req = '0;
        wait_for(1, 10, c);
        check_eq("t1_start_lat", 32'(c), 32'd1);
        check_eq("t1_start", 32'(spi_start), 32'h2);
        check_eq("t1_tx", 32'(spi_data_tx), 32'h00A5C3);
        check_eq("t1_dir", 32'(spi_dir), 32'h0);
        check_eq("t1_busy", 32'(busy), 32'h1);
        tick();
        check_eq("t1_start_pulse", 32'(spi_start), 32'h0);
        check_eq("t1_ack_pulse", 32'(ack), 32'h0);
        wait_for(2, 60, c);
        check_eq("t1_done_lat", 32'(c + 1), 32'd26);
        check_eq("t1_done", 32'(done), 32'h2);
        check_eq("t1_no_err", 32'(err), 32'h0);
        wait_for(7, 10, c);
        check_eq("t1_gap", 32'(c), 32'd4);

        // Round-robin with all three requesters held
        do_reset();
        master_n = 5;
        prio_mode = 1'b0;
        req_ch   = 3'b101;
        req_data = {24'h333333, 24'h222222, 24'h111111};
        req      = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = k % 3;
            wait_for(0, 40, c);
            check_eq($sformatf("rr%0d_ack_lat", k), 32'(c), (k == 0) ? 32'd1 : 32'd12);
            check_eq($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << exp_g));
            wait_for(1, 10, c);
            check_eq($sformatf("rr%0d_start_lat", k), 32'(c), 32'd1);
            check_eq($sformatf("rr%0d_start", k), 32'(spi_start),
                     req_ch[exp_g] ? 32'h2 : 32'h1);
            check_eq($sformatf("rr%0d_tx", k), 32'(spi_data_tx), 32'(req_data[exp_g*DW +: DW]));
        end

        // Fixed priority: 1 first, then 0 raised mid-transaction beats 2
        do_reset();
        prio_mode = 1'b1;
        req_ch    = 3'b000;
        req       = 3'b110;
        wait_for(0, 10, c);
        check_eq("fx_ack1_lat", 32'(c), 32'd1);
        check_eq("fx_ack1", 32'(ack), 32'h2);
        req[1] = 1'b0;
        tick();
        tick();
        tick();
        req[0] = 1'b1;
        wait_for(0, 40, c);
        check_eq("fx_ack0_lat", 32'(c), 32'd10);
        check_eq("fx_ack0", 32'(ack), 32'h1);
        req[0] = 1'b0;
        wait_for(0, 40, c);
        check_eq("fx_ack2_lat", 32'(c), 32'd13);
        check_eq("fx_ack2", 32'(ack), 32'h4);
        req[2] = 1'b0;

        // Channel 0 not ready for 50 cycles; ISSUE must not time out
        do_reset();
        prio_mode = 1'b0;
        hold0     = 1'b1;
        req_ch    = 3'b000;
        req_data[23:0] = 24'h0F0F0F;
        req       = 3'b001;
        wait_for(0, 10, c);
        check_eq("nr_ack_lat", 32'(c), 32'd1);
        check_eq("nr_ack", 32'(ack), 32'h1);
        req = '0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (spi_start != 2'b00 || err != '0) bad++;
        end
        check_eq("nr_quiet", 32'(bad), 32'd0);
        check_eq("nr_busy", 32'(busy), 32'h1);
        hold0 = 1'b0;
        wait_for(1, 10, c);
        check_eq("nr_start_lat", 32'(c), 32'd1);
        check_eq("nr_start", 32'(spi_start), 32'h1);
        check_eq("nr_tx", 32'(spi_data_tx), 32'h0F0F0F);
        wait_for(2, 20, c);
        check_eq("nr_done_lat", 32'(c), 32'd7);
        check_eq("nr_done", 32'(done), 32'h1);
        check_eq("nr_no_err", 32'(err), 32'h0);

        // Reset in WAIT_DONE after rr_ptr has moved to 1
        do_reset();
        master_n  = 8;
        prio_mode = 1'b0;
        req_ch    = 3'b000;
        req       = 3'b011;
        wait_for(0, 10, c);
        check_eq("mr_ack_lat", 32'(c), 32'd1);
        check_eq("mr_ack", 32'(ack), 32'h1);
        wait_for(1, 10, c);
        check_eq("mr_start_lat", 32'(c), 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mr_rst_ack", 32'(ack), 32'h0);
        check_eq("mr_rst_done", 32'(done), 32'h0);
        check_eq("mr_rst_err", 32'(err), 32'h0);
        check_eq("mr_rst_start", 32'(spi_start), 32'h0);
        check_eq("mr_rst_busy", 32'(busy), 32'h0);
        check_eq("mr_rst_tx", 32'(spi_data_tx), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("mr_reack", 32'(ack), 32'h1);

        // Timeout: u_to master never drops ready
        do_reset();
        prio_mode = 1'b0;
        req_ch    = 3'b000;
        req_data  = {24'h654321, 24'h000000, 24'h123456};
        req       = 3'b101;
        wait_for(4, 10, c);
        check_eq("to_ack_lat", 32'(c), 32'd1);
        check_eq("to_ack0", 32'(to_ack), 32'h1);
        req[0] = 1'b0;
        wait_for(5, 10, c);
        check_eq("to_start_lat", 32'(c), 32'd1);
        check_eq("to_start", 32'(to_start), 32'h1);
        check_eq("to_tx", 32'(to_tx), 32'h123456);
        wait_for(6, 40, c);
        check_eq("to_err_lat", 32'(c), 32'd16);
        check_eq("to_err_not_done", 32'({to_done, to_err}), 32'h01);
        wait_for(4, 20, c);
        check_eq("to_next_lat", 32'(c), 32'd5);
        check_eq("to_ack2", 32'(to_ack), 32'h4);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Shares the two SPI write channels between several requesters: ch0 drives the ADF4002 and ch1 drives the LMX2594. Typical requesters are the init sequencer, the UART debug path and the SPI-listener path. The block accepts one 24-bit write per grant and runs the SPI master handshake (start pulse, busy, ready) on the selected channel. It reports done or error back to the requester that owns the grant. The block sits between the control/process logic and the SPI master instances.

Parameters:
NUM_REQ, 3, number of requesters (1..8); requester index 0 has the highest fixed priority.
DATA_W, 24, SPI word width; driven onto spi_data_depth as a constant.
TIMEOUT, 1024, max cycles spent in WAIT_BUSY plus WAIT_DONE before an abort.
GAP_CYC, 4, idle cycles forced between consecutive SPI transactions (CS high time); minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
prio_mode  in  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
req  in  NUM_REQ  per-requester request level; held until ack
req_ch  in  NUM_REQ  per-requester target channel (0 = ADF4002, 1 = LMX2594)
req_data  in  NUM_REQ*DATA_W  per-requester write word; slice i is [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse; request captured
done  out  NUM_REQ  one-cycle pulse; transaction completed
err  out  NUM_REQ  one-cycle pulse; transaction timed out (replaces done)
busy  out  1  high whenever the arbiter is not in IDLE
spi_ready  in  2  per-channel SPI master idle flag
spi_start  out  2  per-channel start pulse
spi_dir  out  1  always 0 (write)
spi_data_tx  out  DATA_W  captured word
spi_data_depth  out  8  constant DATA_W

Behaviour:
- Reset values (synchronous; rst wins over every other event, including mid-transaction): state = IDLE; ack, done, err, spi_start = 0; busy = 0; spi_dir = 0; spi_data_tx = 0; spi_data_depth = DATA_W; rr_ptr = 0; timeout counter = 0. In-flight requests are dropped without done or err, and no SPI start is issued during reset.
- IDLE: if any req bit is high, select the winner:
  - round-robin: the first set bit searching upward from rr_ptr, wrapping at NUM_REQ;
  - fixed: the lowest set bit.
- On selection: capture the winner index (g), req_ch[g] and req_data[g]; pulse ack[g] for one cycle; go to ISSUE. In round-robin mode, set rr_ptr = (g + 1) mod NUM_REQ. Fixed mode leaves rr_ptr unchanged.
- ISSUE: wait for spi_ready[ch] = 1, then pulse spi_start[ch] for exactly one cycle with spi_data_tx stable. Clear the counter and go to WAIT_BUSY.
- WAIT_BUSY: wait for spi_ready[ch] = 0, then go to WAIT_DONE.
- WAIT_DONE: wait for spi_ready[ch] = 1, then pulse done[g] and go to GAP.
- The timeout counter increments in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT-1, pulse err[g] (no done) and go to GAP.
- GAP: count GAP_CYC cycles, then return to IDLE.
- Latency with an ideal master (ready drops one cycle after start, stays low for N cycles):
  - req to ack = 1 cycle;
  - ack to spi_start = 1 cycle if spi_ready[ch] is already high;
  - done is asserted N + 2 cycles after spi_start.
- Throughput: at most one transaction in flight across both channels.
- spi_data_tx and ch are held constant from capture until the next capture.
- A requester that deasserts req before ack is never served. Requests arriving during a transaction wait; no request is lost while req stays high.
- req bits are sampled only in IDLE. Simultaneous requests are resolved by the current mode on that cycle.
- ack, done and err are mutually exclusive per cycle and across requesters.
- Changing prio_mode mid-transaction takes effect at the next IDLE.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding localparams: IDLE = 0, ISSUE = 1, WAIT_BUSY = 2, WAIT_DONE = 3, GAP = 4;
  - CH_ADF4002 = 0 and CH_LMX2594 = 1;
  - default DATA_W, TIMEOUT and GAP_CYC.
- Sub-module rr_pick: a combinational round-robin/fixed selector with inputs req, ptr, mode and outputs valid and index. It is the only natural split.

Test Plan:
- Single request: req[1] = 1, ch = 1, data = 24'h00A5C3, ideal master busy for 24 cycles → ack[1] pulses once; spi_start = 2'b10 for 1 cycle with spi_data_tx = 24'h00A5C3 and spi_dir = 0; done[1] pulses 26 cycles after start; GAP of 4 cycles before the next grant.
- Round-robin: req = 3'b111 held, prio_mode = 0 → ack order 0, 1, 2, 0, 1, 2; each ack is separated by a full transaction plus GAP.
- Fixed priority: req = 3'b110, then req[0] raised during the req[1] transaction, prio_mode = 1 → order is 1, 0, 2 (req[0] wins the next IDLE over req[2]).
- Channel not ready: spi_ready[0] held at 0 with req on ch 0 for 50 cycles, then released → no spi_start until release; ack is still on cycle 1; no err, because ISSUE is not timed.
- Timeout: the master never drops ready after start (TIMEOUT = 16) → err[g] pulses 16 cycles after start; done is never pulsed; the next requester is served after GAP.
- Reset mid-transaction: rst = 1 for 1 cycle in WAIT_DONE → all outputs return to reset values next cycle; no done or err; a held req is re-acked starting from rr_ptr = 0.
